// File: rtl/sound_pkg.sv
// Note encoding, tone half-periods (clk cycles at 100 MHz) and the sound-code to note-sequence ROM.
package sound_pkg;

   typedef enum logic [3:0] {
      REST = 4'd0, C4 = 4'd1, E4 = 4'd2, G4 = 4'd3, C5 = 4'd4,
      E5 = 4'd5, G5 = 4'd6, A5 = 4'd7, C6 = 4'd8
   } note_e;

   typedef logic [3:0][3:0] seq_t;

   localparam logic [17:0] HP_C4 = 18'd190840;
   localparam logic [17:0] HP_E4 = 18'd151686;
   localparam logic [17:0] HP_G4 = 18'd127551;
   localparam logic [17:0] HP_C5 = 18'd95557;
   localparam logic [17:0] HP_E5 = 18'd75843;
   localparam logic [17:0] HP_G5 = 18'd63776;
   localparam logic [17:0] HP_A5 = 18'd56818;
   localparam logic [17:0] HP_C6 = 18'd47778;

   localparam logic [2:0] SND_MOVE    = 3'd1;
   localparam logic [2:0] SND_SELECT  = 3'd2;
   localparam logic [2:0] SND_CAPTURE = 3'd3;
   localparam logic [2:0] SND_CHECK   = 3'd4;
   localparam logic [2:0] SND_ILLEGAL = 3'd5;
   localparam logic [2:0] SND_WIN     = 3'd6;
   localparam logic [2:0] SND_LOSE    = 3'd7;

   // Unused slots stay REST, which terminates the sequence.
   function automatic seq_t code_seq(input logic [2:0] code);
      seq_t s;
      s = '0;
      case (code)
         SND_MOVE:    s[0] = E5;
         SND_SELECT:  s[0] = G5;
         SND_CAPTURE: begin s[0] = C5; s[1] = G5; end
         SND_CHECK:   begin s[0] = A5; s[1] = A5; end
         SND_ILLEGAL: s[0] = C4;
         SND_WIN:     begin s[0] = C5; s[1] = E5; s[2] = G5; s[3] = C6; end
         SND_LOSE:    begin s[0] = G4; s[1] = E4; s[2] = C4; end
         default:     s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sound_tone_gen.sv
// Square-wave generator: phase counter plus toggle flop, restarted by load and silenced when disabled.
module sound_tone_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [17:0] half_period,
   output logic        pwm
);
   logic [17:0] hp_q, hp_d;
   logic [17:0] cnt_q, cnt_d;
   logic        pwm_q, pwm_d;

   // Next phase/toggle state.
   always_comb begin
      hp_d  = hp_q;
      cnt_d = cnt_q;
      pwm_d = pwm_q;
      if (load) begin
         hp_d  = half_period;
         cnt_d = 18'd0;
         pwm_d = 1'b0;
      end else if (en) begin
         if (cnt_q == hp_q - 18'd1) begin
            cnt_d = 18'd0;
            pwm_d = ~pwm_q;
         end else begin
            cnt_d = cnt_q + 18'd1;
         end
      end else begin
         cnt_d = 18'd0;
         pwm_d = 1'b0;
      end
   end

   // Tone state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hp_q  <= 18'd0;
         cnt_q <= 18'd0;
         pwm_q <= 1'b0;
      end else begin
         hp_q  <= hp_d;
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm = pwm_q;
endmodule

// File: rtl/sound_scheduler.sv
// Request FIFO plus note/gap sequencer driving the PWM audio pin; game-end codes pre-empt everything.
// Optional SOUND_DEDUP_EN: drop a request equal to the FIFO tail (or the playing code when the FIFO is empty).
module sound_scheduler
   import sound_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int NOTE_CYC   = 10000000,
   parameter int GAP_CYC    = 2000000,
   parameter int HP_DIV     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [2:0] req_code,
   output logic       pwm,
   output logic       busy,
   output logic       overflow,
   output logic [2:0] cur_code
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   // HP_DIV shrinks every pitch uniformly so short simulated notes still show toggles.
   localparam logic [17:0] HPS_C4 = 18'(HP_C4 / HP_DIV);
   localparam logic [17:0] HPS_E4 = 18'(HP_E4 / HP_DIV);
   localparam logic [17:0] HPS_G4 = 18'(HP_G4 / HP_DIV);
   localparam logic [17:0] HPS_C5 = 18'(HP_C5 / HP_DIV);
   localparam logic [17:0] HPS_E5 = 18'(HP_E5 / HP_DIV);
   localparam logic [17:0] HPS_G5 = 18'(HP_G5 / HP_DIV);
   localparam logic [17:0] HPS_A5 = 18'(HP_A5 / HP_DIV);
   localparam logic [17:0] HPS_C6 = 18'(HP_C6 / HP_DIV);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, NOTE = 2'd2, GAP = 2'd3} state_e;

   state_e        state_q, state_d;
   logic [1:0]    slot_q, slot_d;
   logic [2:0]    cur_code_q, cur_code_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    mem_q [FIFO_DEPTH];
   logic [2:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d, busy_q, busy_d;
   logic          preempt_s, queue_req_s, dup_s, full_s, pop_s, push_s;
   seq_t          cur_seq_s, load_seq_s;
   logic [3:0]    cur_note_s, next_note_s, load_note_s;
   logic [17:0]   load_hp_s;

   // Request classification and FIFO handshake.
   always_comb begin
      preempt_s   = req_valid & (req_code >= SND_WIN);
      queue_req_s = req_valid & (req_code != 3'd0) & (req_code < SND_WIN);
      full_s      = (count_q == CW'(FIFO_DEPTH));
      pop_s       = (state_q == IDLE) & (count_q != CW'(0)) & ~preempt_s;
      dup_s       = 1'b0;
`ifdef SOUND_DEDUP_EN
      if (count_q != CW'(0)) begin
         dup_s = (req_code == mem_q[wr_ptr_q - AW'(1)]);
      end else begin
         dup_s = (state_q != IDLE) & (req_code == cur_code_q);
      end
`endif
      push_s = queue_req_s & ~dup_s & (~full_s | pop_s);
   end

   // FIFO next state; a pre-empt flushes it.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (queue_req_s & ~dup_s & ~push_s);
      if (preempt_s) begin
         wr_ptr_d = AW'(0);
         rd_ptr_d = AW'(0);
         count_d  = CW'(0);
      end else begin
         if (push_s) begin
            mem_d[wr_ptr_q] = req_code;
         end else begin
            mem_d = mem_q;
         end
         wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
         count_d  = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // Sequencer next state.
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      cur_code_d  = cur_code_q;
      timer_d     = timer_q;
      cur_seq_s   = code_seq(cur_code_q);
      cur_note_s  = cur_seq_s[slot_q];
      next_note_s = cur_seq_s[slot_q + 2'd1];
      if (preempt_s) begin
         state_d    = LOAD;
         cur_code_d = req_code;
         slot_d     = 2'd0;
         timer_d    = TW'(0);
      end else begin
         case (state_q)
            IDLE: begin
               cur_code_d = 3'd0;
               if (pop_s) begin
                  cur_code_d = mem_q[rd_ptr_q];
                  slot_d     = 2'd0;
                  state_d    = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD: begin
               timer_d = TW'(0);
               if (cur_note_s == REST) begin
                  state_d    = IDLE;
                  cur_code_d = 3'd0;
               end else begin
                  state_d = NOTE;
               end
            end
            NOTE: begin
               if (timer_q == TW'(NOTE_CYC - 1)) begin
                  timer_d = TW'(0);
                  state_d = GAP;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            GAP: begin
               if (timer_q == TW'(GAP_CYC - 1)) begin
                  timer_d = TW'(0);
                  slot_d  = slot_q + 2'd1;
                  if ((slot_q == 2'd3) || (next_note_s == REST)) begin
                     state_d    = IDLE;
                     cur_code_d = 3'd0;
                  end else begin
                     state_d = LOAD;
                  end
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: begin
               state_d    = IDLE;
               cur_code_d = 3'd0;
            end
         endcase
      end
      busy_d = (state_d != IDLE) | (count_d != CW'(0));
   end

   // Pitch of the note about to be loaded, so the tone generator lines up with the state register.
   always_comb begin
      load_seq_s  = code_seq(cur_code_d);
      load_note_s = load_seq_s[slot_d];
      case (load_note_s)
         C4:      load_hp_s = HPS_C4;
         E4:      load_hp_s = HPS_E4;
         G4:      load_hp_s = HPS_G4;
         C5:      load_hp_s = HPS_C5;
         E5:      load_hp_s = HPS_E5;
         G5:      load_hp_s = HPS_G5;
         A5:      load_hp_s = HPS_A5;
         C6:      load_hp_s = HPS_C6;
         default: load_hp_s = 18'd0;
      endcase
   end

   // State, FIFO and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         slot_q     <= 2'd0;
         cur_code_q <= 3'd0;
         timer_q    <= TW'(0);
         wr_ptr_q   <= AW'(0);
         rd_ptr_q   <= AW'(0);
         count_q    <= CW'(0);
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 3'd0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         cur_code_q <= cur_code_d;
         timer_q    <= timer_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   sound_tone_gen u_tone (
      .clk         (clk),
      .rst         (rst),
      .en          (state_d == NOTE),
      .load        (state_d == LOAD),
      .half_period (load_hp_s),
      .pwm         (pwm)
   );

   assign busy     = busy_q;
   assign overflow = overflow_q;
   assign cur_code = cur_code_q;
endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: timeline model of queue + note schedule, checked every cycle, plus directed pins.
// Define SOUND_DEDUP_EN for the bench and the RTL together to check the dedup variant.
module tb_sound_scheduler;
   localparam int DEPTH = 4;
   localparam int NOTE  = 20;
   localparam int GAP   = 5;
   localparam int DIV   = 20000;
   localparam int L     = 1 + NOTE + GAP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [2:0] req_code = 3'd0;
   logic       pwm, busy, overflow;
   logic [2:0] cur_code;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   logic       s_rst = 1'b1;
   logic       s_valid = 1'b0;
   logic [2:0] s_code = 3'd0;

   int q[$];
   bit m_active = 1'b0;
   int m_cur = 0;
   int m_o = 0;
   bit m_ovf = 1'b0;

   sound_scheduler #(.FIFO_DEPTH(DEPTH), .NOTE_CYC(NOTE), .GAP_CYC(GAP), .HP_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
      .pwm(pwm), .busy(busy), .overflow(overflow), .cur_code(cur_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      s_rst   <= rst;
      s_valid <= req_valid;
      s_code  <= req_code;
      cyc     <= cyc + 1;
   end

   function automatic int nnotes(input int code);
      case (code)
         1, 2, 5: return 1;
         3, 4:    return 2;
         6:       return 4;
         7:       return 3;
         default: return 0;
      endcase
   endfunction

   // Raw half-period of note j of a code's melody.
   function automatic int raw_hp(input int code, input int j);
      int t[8][4];
      t[1] = '{75843, 0, 0, 0};
      t[2] = '{63776, 0, 0, 0};
      t[3] = '{95557, 63776, 0, 0};
      t[4] = '{56818, 56818, 0, 0};
      t[5] = '{190840, 0, 0, 0};
      t[6] = '{95557, 75843, 63776, 47778};
      t[7] = '{127551, 151686, 190840, 0};
      t[0] = '{0, 0, 0, 0};
      return t[code][j];
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, got, exp);
      end
   endtask

   // One clock edge of the model: queue of codes plus the offset into the playing melody.
   task automatic model_step(input bit r, input bit v, input int c);
      bit was_active, dup, pop, qreq;
      int sz;
      if (r) begin
         q.delete();
         m_active = 1'b0; m_cur = 0; m_o = 0; m_ovf = 1'b0;
         return;
      end
      was_active = m_active;
      sz = q.size();
      qreq = v && c >= 1 && c <= 5;
      dup = 1'b0;
`ifdef SOUND_DEDUP_EN
      if (qreq) dup = (sz > 0) ? (q[sz-1] == c) : (was_active && m_cur == c);
`endif
      if (v && c >= 6) begin
         q.delete();
         m_active = 1'b1; m_cur = c; m_o = 0;
      end else begin
         pop = !was_active && sz > 0;
         if (pop) begin
            m_cur = q.pop_front(); m_active = 1'b1; m_o = 0;
         end else if (was_active) begin
            m_o++;
            if (m_o == nnotes(m_cur) * L) begin m_active = 1'b0; m_cur = 0; end
         end
         if (qreq && !dup) begin
            if (sz < DEPTH || pop) q.push_back(c);
            else m_ovf = 1'b1;
         end
      end
   endtask

   initial begin
      int j, w, e_pwm;
      forever begin
         @(negedge clk);
         model_step(s_rst, s_valid, int'(s_code));
         e_pwm = 0;
         if (m_active) begin
            j = m_o / L;
            w = m_o % L;
            if (w >= 1 && w <= NOTE) e_pwm = (w / (raw_hp(m_cur, j) / DIV)) % 2;
         end
         check("model_cur_code", cur_code, 8'(m_active ? m_cur : 0));
         check("model_busy", busy, 8'(m_active || q.size() > 0));
         check("model_overflow", overflow, 8'(m_ovf));
         check("model_pwm", pwm, 8'(e_pwm));
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic send(input logic [2:0] c);
      req_valid = 1'b1; req_code = c;
      step(1);
      req_valid = 1'b0; req_code = 3'd0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < budget) begin step(1); k++; end
      check("wait_idle", busy, 8'd0);
      step(2);
   endtask

   initial begin
      logic [2:0] c;
      step(3);
      check("rst_pwm", pwm, 8'd0);
      check("rst_busy", busy, 8'd0);
      check("rst_overflow", overflow, 8'd0);
      check("rst_cur_code", cur_code, 8'd0);
      rst = 1'b0;
      step(2);

      send(3'd0);
      step(3);
      check("code0_ignored", busy, 8'd0);

      send(3'd1);
      check("s1_busy_t", busy, 8'd1);
      step(1);
      check("s1_cur_t1", cur_code, 8'd1);
      step(1);
      check("s1_pwm_note_start", pwm, 8'd0);
      step(2);
      check("s1_pwm_first_toggle", pwm, 8'd1);
      step(22);
      check("s1_busy_in_gap", busy, 8'd1);
      step(2);
      check("s1_idle_busy", busy, 8'd0);
      check("s1_idle_cur", cur_code, 8'd0);
      step(2);

      send(3'd3); send(3'd4); send(3'd2);
      check("s2_overflow", overflow, 8'd0);
      step(60);
      check("s2_second_code", cur_code, 8'd4);
      wait_idle(300);
      check("s2_overflow_end", overflow, 8'd0);

      send(3'd1); send(3'd2); send(3'd3); send(3'd4); send(3'd5); send(3'd1);
      check("s3_overflow_set", overflow, 8'd1);
      wait_idle(600);
      check("s3_overflow_sticky", overflow, 8'd1);
      rst = 1'b1;
      step(1);
      check("s3_overflow_cleared", overflow, 8'd0);
      rst = 1'b0;
      step(2);

      send(3'd3); send(3'd1); send(3'd2);
      step(10);
      send(3'd7);
      check("s4_preempt_cur", cur_code, 8'd7);
      check("s4_preempt_pwm", pwm, 8'd0);
      step(77);
      check("s4_last_gap_busy", busy, 8'd1);
      step(1);
      check("s4_flushed_idle", busy, 8'd0);
      step(2);

      send(3'd5);
      step(10);
      check("s5_pwm_high", pwm, 8'd1);
      rst = 1'b1;
      step(1);
      check("s5_rst_pwm", pwm, 8'd0);
      check("s5_rst_busy", busy, 8'd0);
      check("s5_rst_cur", cur_code, 8'd0);
      rst = 1'b0;
      step(2);

      send(3'd1); send(3'd1);
      step(39);
`ifdef SOUND_DEDUP_EN
      check("s6_dedup_single", busy, 8'd0);
`else
      check("s6_two_sequences", busy, 8'd1);
`endif
      wait_idle(200);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            c = 3'($urandom_range(0, 7));
            if (c >= 3'd6 && $urandom_range(0, 3) != 0) c = 3'($urandom_range(1, 5));
            send(c);
         end else begin
            step(1);
         end
      end
      wait_idle(1500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
